vec_sequencer: RTL and testbench

Multi-beat sequencer for the vector datapath. The vector ALU and vector register file process `LANES` elements per cycle. This block splits a vector instruction of up to 2^`VLEN_W`−1 elements into beats and drives the group index, lane mask and vector write enable for each beat. It stalls the scalar PC and instruction fetch until the final beat, and sits between the decoder/condition logic and the vector register file.

---
 rtl/vec_sequencer.sv | 104 ++++++++++
 tb/tb_vec_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_sequencer.sv
// Multi-beat vector sequencer: splits a vector op into LANES-wide beats and stalls fetch until the last one.
// Optional active-cycle counter enabled by defining VSEQ_PERF_CNT_EN.
module vec_sequencer #(
  parameter int LANES  = 5,
  parameter int VLEN_W = 4,
  parameter int GW     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [VLEN_W-1:0] vlen,
  input  logic              cond_ok,
  input  logic              abort,
  output logic              stall,
  output logic              vwe,
  output logic [GW-1:0]     group,
  output logic [LANES-1:0]  lane_mask,
  output logic              busy,
  output logic              done,
  output logic [15:0]       busy_cycles
);

  localparam int AW = VLEN_W + GW;
  // Element index needs headroom for group*LANES + lane
  localparam int EW = AW + $clog2(LANES + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        st_reg, st_next;
  logic [GW-1:0] b_reg, b_next;
  logic [AW-1:0] nbeats;
  logic [AW-1:0] cur;
  logic          active;
  logic          last;

  assign nbeats = (AW'(vlen) + AW'(LANES - 1)) / AW'(LANES);
  assign cur    = (st_reg == RUN) ? AW'(b_reg) : '0;
  // Reset also masks the combinational outputs so nothing is written while it is held
  assign active = ~reset & (((st_reg == IDLE) & start) | (st_reg == RUN));
  assign last   = (vlen == '0) | (cur == nbeats - AW'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_reg <= IDLE;
      b_reg  <= '0;
    end else begin
      st_reg <= st_next;
      b_reg  <= b_next;
    end
  end

  always_comb begin
    st_next = st_reg;
    b_next  = b_reg;
    stall   = active & ~last & ~abort;
    vwe     = active & cond_ok & (vlen != '0) & ~abort;
    done    = active & (last | abort);
    busy    = (st_reg == RUN);
    group   = active ? cur[GW-1:0] : '0;
    case (st_reg)
      IDLE: begin
        if (active & ~last & ~abort) begin
          st_next = RUN;
          b_next  = GW'(1);
        end
      end
      RUN: begin
        if (last | abort) begin
          st_next = IDLE;
          b_next  = '0;
        end else begin
          b_next = b_reg + GW'(1);
        end
      end
      default: begin
        st_next = IDLE;
        b_next  = '0;
      end
    endcase
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [EW-1:0] elem;
    assign elem          = EW'(cur) * EW'(LANES) + EW'(gi);
    assign lane_mask[gi] = active & (elem < EW'(vlen));
  end

`ifdef VSEQ_PERF_CNT_EN
  logic [15:0] cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (active && (cnt_reg != 16'hFFFF)) begin
      cnt_reg <= cnt_reg + 16'd1;
    end
  end

  assign busy_cycles = cnt_reg;
`else
  assign busy_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_vec_sequencer.sv
// Bench for vec_sequencer: beat-level reference model checked every cycle,
// directed literal sequences, then randomized back-to-back operations.
module tb_vec_sequencer;

  localparam int LANES  = 5;
  localparam int VLEN_W = 4;
  localparam int GW     = 2;

  logic              clk;
  logic              reset;
  logic              start;
  logic [VLEN_W-1:0] vlen;
  logic              cond_ok;
  logic              abort;
  logic              stall;
  logic              vwe;
  logic [GW-1:0]     group;
  logic [LANES-1:0]  lane_mask;
  logic              busy;
  logic              done;
  logic [15:0]       busy_cycles;

  int checks = 0;
  int errors = 0;

  vec_sequencer #(.LANES(LANES), .VLEN_W(VLEN_W), .GW(GW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .vlen       (vlen),
    .cond_ok    (cond_ok),
    .abort      (abort),
    .stall      (stall),
    .vwe        (vwe),
    .group      (group),
    .lane_mask  (lane_mask),
    .busy       (busy),
    .done       (done),
    .busy_cycles(busy_cycles)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: "inside an op" flag plus the index of the beat being executed.
  bit m_in_op;
  int m_k;
  int m_cnt;

  function automatic int beats_of(input int v);
    return (v + LANES - 1) / LANES;
  endfunction

  function automatic bit m_active();
    return !reset && (m_in_op || start);
  endfunction

  function automatic int m_beat();
    return m_in_op ? m_k : 0;
  endfunction

  function automatic bit m_done();
    return m_active() && (abort || (m_beat() + 1 >= beats_of(int'(vlen))));
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_in_op <= 1'b0;
      m_k     <= 0;
      m_cnt   <= 0;
    end else begin
      if (m_active() && m_cnt < 65535) m_cnt <= m_cnt + 1;
      if (m_active() && !m_done()) begin
        m_in_op <= 1'b1;
        m_k     <= m_beat() + 1;
      end else begin
        m_in_op <= 1'b0;
        m_k     <= 0;
      end
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Per-cycle compare of every output against the model
  always @(negedge clk) begin : compare
    bit         act;
    int         k;
    int         v;
    logic [4:0] em;
    act = m_active();
    k   = m_beat();
    v   = int'(vlen);
    em  = '0;
    for (int i = 0; i < LANES; i++) em[i] = act && (k * LANES + i < v);
    cmp("m_stall", 32'(stall), 32'(act && !abort && (k + 1 < beats_of(v))));
    cmp("m_vwe", 32'(vwe), 32'(act && cond_ok && v != 0 && !abort));
    cmp("m_done", 32'(done), 32'(m_done()));
    cmp("m_busy", 32'(busy), 32'(m_in_op));
    cmp("m_group", 32'(group), act ? 32'(k) : 32'd0);
    cmp("m_mask", 32'(lane_mask), 32'(em));
`ifdef VSEQ_PERF_CNT_EN
    cmp("m_busy_cycles", 32'(busy_cycles), 32'(m_cnt));
`else
    cmp("m_busy_cycles", 32'(busy_cycles), 32'd0);
`endif
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One cycle of hand-computed expectations
  task automatic lit_cycle(input string tag, input int g, input logic [4:0] m,
                           input bit s, input bit w, input bit d, input bit b);
    @(negedge clk);
    cmp({tag, ".group"}, 32'(group), 32'(g));
    cmp({tag, ".mask"}, 32'(lane_mask), 32'(m));
    cmp({tag, ".stall"}, 32'(stall), 32'(s));
    cmp({tag, ".vwe"}, 32'(vwe), 32'(w));
    cmp({tag, ".done"}, 32'(done), 32'(d));
    cmp({tag, ".busy"}, 32'(busy), 32'(b));
    next_cycle();
  endtask

  task automatic zero_outputs(input string tag);
    cmp({tag, ".stall"}, 32'(stall), 32'd0);
    cmp({tag, ".vwe"}, 32'(vwe), 32'd0);
    cmp({tag, ".done"}, 32'(done), 32'd0);
    cmp({tag, ".busy"}, 32'(busy), 32'd0);
    cmp({tag, ".group"}, 32'(group), 32'd0);
    cmp({tag, ".mask"}, 32'(lane_mask), 32'd0);
    cmp({tag, ".busy_cycles"}, 32'(busy_cycles), 32'd0);
  endtask

  // Issue one instruction, holding start until the model says the op is over
  task automatic run_op(input logic [3:0] v, input logic c, input int ab);
    int beat;
    beat    = 0;
    start   = 1'b1;
    vlen    = v;
    cond_ok = c;
    do begin
      abort = (beat == ab);
      next_cycle();
      beat++;
    end while (m_in_op && beat < 20);
    abort = 1'b0;
    if (beat >= 20) begin
      checks++;
      errors++;
      $display("FAIL op_timeout: got %0d cycles required at most 3", beat);
    end
    $display("op vlen=%0d cond_ok=%0d abort_beat=%0d cycles=%0d", v, c, ab, beat);
  endtask

  initial begin
    int exp_cnt;
    reset   = 1'b1;
    start   = 1'b1;
    vlen    = 4'd3;
    cond_ok = 1'b1;
    abort   = 1'b0;
    #2;
    zero_outputs("reset");
    next_cycle();
    reset = 1'b0;
    lit_cycle("release_vlen3", 0, 5'b00111, 0, 1, 1, 0);

    vlen = 4'd12;
    lit_cycle("v12_b0", 0, 5'b11111, 1, 1, 0, 0);
    lit_cycle("v12_b1", 1, 5'b11111, 1, 1, 0, 1);
    lit_cycle("v12_b2", 2, 5'b00011, 0, 1, 1, 1);

    vlen = 4'd5;
    lit_cycle("v5", 0, 5'b11111, 0, 1, 1, 0);
    vlen = 4'd0;
    lit_cycle("v0", 0, 5'b00000, 0, 0, 1, 0);

    vlen    = 4'd15;
    cond_ok = 1'b0;
    lit_cycle("v15nc_b0", 0, 5'b11111, 1, 0, 0, 0);
    lit_cycle("v15nc_b1", 1, 5'b11111, 1, 0, 0, 1);
    lit_cycle("v15nc_b2", 2, 5'b11111, 0, 0, 1, 1);

    cond_ok = 1'b1;
    lit_cycle("abort_b0", 0, 5'b11111, 1, 1, 0, 0);
    abort = 1'b1;
    lit_cycle("abort_b1", 1, 5'b11111, 0, 0, 1, 1);
    abort = 1'b0;
    vlen  = 4'd7;
    lit_cycle("after_abort_b0", 0, 5'b11111, 1, 1, 0, 0);
    lit_cycle("after_abort_b1", 1, 5'b00011, 0, 1, 1, 1);

    vlen = 4'd15;
    lit_cycle("midrst_b0", 0, 5'b11111, 1, 1, 0, 0);
    reset = 1'b1;
    #1;
    zero_outputs("midrst");
    next_cycle();
    reset = 1'b0;
    lit_cycle("postrst_b0", 0, 5'b11111, 1, 1, 0, 0);
    lit_cycle("postrst_b1", 1, 5'b11111, 1, 1, 0, 1);
    lit_cycle("postrst_b2", 2, 5'b11111, 0, 1, 1, 1);

    // Counter: two 3-beat ops and one no-op after a fresh reset
    start = 1'b0;
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    run_op(4'd12, 1'b1, -1);
    run_op(4'd12, 1'b1, -1);
    run_op(4'd0, 1'b1, -1);
    start = 1'b0;
`ifdef VSEQ_PERF_CNT_EN
    exp_cnt = 7;
`else
    exp_cnt = 0;
`endif
    @(negedge clk);
    cmp("busy_cycles_7", 32'(busy_cycles), 32'(exp_cnt));
    next_cycle();

    for (int n = 0; n < 200; n++) begin
      int gap;
      int ab;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        start   = 1'b0;
        vlen    = 4'($urandom_range(0, 15));
        cond_ok = 1'($urandom_range(0, 1));
        abort   = 1'($urandom_range(0, 1));
        next_cycle();
      end
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
      run_op(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), ab);
    end
    start = 1'b0;
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
